// File: rtl/cmd_sched.sv
// -----------------------------------------------------------------------------
// cmd_sched
//
// Sequences one command packet at a time through an external packet parser.
// When enabled and the command FIFO holds at least one full packet, it starts
// the parser. It then waits for done or error, or gives up after a timeout.
// A good packet is handed downstream as a one-cycle config strobe once the
// consumer is ready. A failed packet resets the parser and flushes the FIFO.
//
// Every output is a flop. Outputs that follow the state are loaded from the
// next-state decode, so they line up with the state register cycle for cycle.
// cfg_stb and pkt_cnt update on the same edge that leaves APPLY.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous reset, active low
//   en         in   1  allows new packets to be started
//   fifoc_cnt  in   8  bytes currently held in the command FIFO
//   fifoc_clr  out  1  one-cycle FIFO flush pulse (FLUSH state)
//   parse_fs   out  1  parser start level (START and WAIT)
//   parse_fd   in   1  parser done level
//   parse_err  in   1  parser sticky error level
//   parse_rst  out  1  parser reset (FAIL state, and while rst is low)
//   cfg_rdy    in   1  downstream can accept new configuration
//   cfg_stb    out  1  one-cycle pulse: apply parser config registers
//   pkt_cnt    out  8  good packets applied, saturating at 255
//   err_cnt    out  8  failed packets (error or timeout), saturating at 255
//   busy       out  1  high in every state except IDLE
//   so         out  4  current state encoding, for debug
// -----------------------------------------------------------------------------
module cmd_sched #(
    parameter int PKT_LEN = 12,
    parameter int TMO_CYC = 64,
    parameter int RST_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] fifoc_cnt,
    output logic       fifoc_clr,
    output logic       parse_fs,
    input  logic       parse_fd,
    input  logic       parse_err,
    output logic       parse_rst,
    input  logic       cfg_rdy,
    output logic       cfg_stb,
    output logic [7:0] pkt_cnt,
    output logic [7:0] err_cnt,
    output logic       busy,
    output logic [3:0] so
);

    localparam logic [7:0]  PKT_LEN_B = 8'(PKT_LEN);
    localparam logic [15:0] TMO_LAST  = 16'(TMO_CYC - 1);
    localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DROP  = 3'd3,
        S_APPLY = 3'd4,
        S_FAIL  = 3'd5,
        S_FLUSH = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tmo_cnt;
    logic [15:0] rst_cnt;
    logic        apply_fire;
    logic        fail_entry;

    // Saturating event counter increment: holds at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign apply_fire = (state == S_APPLY) && cfg_rdy;
    assign fail_entry = (state_nxt == S_FAIL) && (state != S_FAIL);

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en && (fifoc_cnt >= PKT_LEN_B)) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                // An error beats a simultaneous done.
                if (parse_err)                 state_nxt = S_FAIL;
                else if (parse_fd)             state_nxt = S_DROP;
                else if (tmo_cnt == TMO_LAST)  state_nxt = S_FAIL;
            end
            // Wait for the parser to drop done so it cannot be seen again.
            S_DROP:  if (!parse_fd) state_nxt = S_APPLY;
            S_APPLY: if (cfg_rdy)   state_nxt = S_IDLE;
            S_FAIL:  if (rst_cnt == RST_LAST) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, cycle counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= 16'd0;
            rst_cnt   <= 16'd0;
            parse_fs  <= 1'b0;
            parse_rst <= 1'b1;
            fifoc_clr <= 1'b0;
            cfg_stb   <= 1'b0;
            pkt_cnt   <= 8'd0;
            err_cnt   <= 8'd0;
            busy      <= 1'b0;
            so        <= 4'd0;
        end else begin
            state <= state_nxt;

            // Both counters restart from 0 on entry and read 0 outside their state.
            tmo_cnt <= ((state == S_WAIT) && (state_nxt == S_WAIT)) ? tmo_cnt + 16'd1 : 16'd0;
            rst_cnt <= ((state == S_FAIL) && (state_nxt == S_FAIL)) ? rst_cnt + 16'd1 : 16'd0;

            parse_fs  <= (state_nxt == S_START) || (state_nxt == S_WAIT);
            parse_rst <= (state_nxt == S_FAIL);
            fifoc_clr <= (state_nxt == S_FLUSH);
            busy      <= (state_nxt != S_IDLE);
            so        <= {1'b0, state_nxt};

            cfg_stb <= apply_fire;
            if (apply_fire) pkt_cnt <= sat_inc(pkt_cnt);
            if (fail_entry) err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_cmd_sched
//
// Directed bench for cmd_sched. The parser, the FIFO and the downstream
// consumer are played by the initial block. Each packet pushes its expected
// final counter value onto a queue. The value is popped and compared when the
// DUT produces the matching event: cfg_stb for good packets, fifoc_clr for
// failed ones.
// -----------------------------------------------------------------------------
module tb_cmd_sched;

    localparam int PKT_LEN = 12;
    localparam int TMO_CYC = 64;
    localparam int RST_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] fifoc_cnt = 8'd0;
    logic       fifoc_clr;
    logic       parse_fs;
    logic       parse_fd = 1'b0;
    logic       parse_err = 1'b0;
    logic       parse_rst;
    logic       cfg_rdy = 1'b0;
    logic       cfg_stb;
    logic [7:0] pkt_cnt;
    logic [7:0] err_cnt;
    logic       busy;
    logic [3:0] so;

    int n_chk  = 0;
    int n_fail = 0;
    int pkt_model = 0;
    int err_model = 0;
    int exp_pkt_q[$];
    int exp_err_q[$];

    cmd_sched #(
        .PKT_LEN(PKT_LEN),
        .TMO_CYC(TMO_CYC),
        .RST_CYC(RST_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifoc_cnt (fifoc_cnt),
        .fifoc_clr (fifoc_clr),
        .parse_fs  (parse_fs),
        .parse_fd  (parse_fd),
        .parse_err (parse_err),
        .parse_rst (parse_rst),
        .cfg_rdy   (cfg_rdy),
        .cfg_stb   (cfg_stb),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
        .busy      (busy),
        .so        (so)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, required finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for cfg_stb, then score pkt_cnt against the queued expectation.
    task automatic wait_stb(input string tag);
        int  n;
        bit  got;
        int  exp;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (cfg_stb) got = 1'b1;
        end
        check({tag, "_stb_seen"}, 32'(got), 1);
        exp = (exp_pkt_q.size() > 0) ? exp_pkt_q.pop_front() : -1;
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), exp);
    endtask

    // Called with FAIL already observed; follows it to the FLUSH pulse.
    task automatic wait_flush(input string tag);
        int rst_cyc;
        int stb_n;
        int n;
        bit got;
        int exp;
        rst_cyc = int'(parse_rst);
        stb_n   = 0;
        n       = 0;
        got     = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            stb_n += int'(cfg_stb);
            if (fifoc_clr) got = 1'b1;
            else rst_cyc += int'(parse_rst);
        end
        check({tag, "_clr_seen"}, 32'(got), 1);
        check({tag, "_prst_cycles"}, rst_cyc, RST_CYC);
        check({tag, "_no_stb"}, stb_n, 0);
        check({tag, "_flush_prst"}, 32'(parse_rst), 0);
        check({tag, "_flush_so"}, 32'(so), 6);
        exp = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : -1;
        check({tag, "_err_cnt"}, 32'(err_cnt), exp);
        tick();
        check({tag, "_clr_once"}, 32'(fifoc_clr), 0);
        check({tag, "_idle_so"}, 32'(so), 0);
    endtask

    // One good packet: done after fd_after WAIT cycles, cfg_rdy low for the
    // first rdy_wait APPLY cycles. drop_en clears en just after START and
    // leaves a full FIFO behind.
    task automatic run_good(input int fd_after, input int rdy_wait, input bit detail, input bit drop_en);
        int fs_cnt;
        int stb_early;
        pkt_model = sat(pkt_model);
        exp_pkt_q.push_back(pkt_model);
        fifoc_cnt = 8'(PKT_LEN);
        cfg_rdy   = (rdy_wait == 0);
        tick();
        if (detail) begin
            check("start_so", 32'(so), 1);
            check("start_fs", 32'(parse_fs), 1);
            check("start_busy", 32'(busy), 1);
        end
        fs_cnt = int'(parse_fs);
        if (drop_en) en = 1'b0;
        else fifoc_cnt = 8'd0;
        for (int i = 1; i <= fd_after; i++) begin
            tick();
            fs_cnt += int'(parse_fs);
            if (i == fd_after) parse_fd = 1'b1;
        end
        tick();
        parse_fd = 1'b0;
        if (detail) begin
            check("drop_so", 32'(so), 3);
            check("drop_fs", 32'(parse_fs), 0);
        end
        tick();
        if (detail) check("apply_so", 32'(so), 4);
        stb_early = 0;
        for (int i = 1; i < rdy_wait; i++) begin
            stb_early += int'(cfg_stb);
            tick();
        end
        stb_early += int'(cfg_stb);
        if (detail) check("apply_hold_so", 32'(so), 4);
        cfg_rdy = 1'b1;
        wait_stb("good");
        if (detail) begin
            check("fs_cycles", fs_cnt, fd_after + 1);
            check("stb_early", stb_early, 0);
            check("stb_idle_so", 32'(so), 0);
            tick();
            check("stb_once", 32'(cfg_stb), 0);
        end
    endtask

    initial begin
        int wcnt;
        int stb_n;

        // Reset values while rst is low
        #1 rst = 1'b0;
        #2;
        check("rst_so", 32'(so), 0);
        check("rst_fs", 32'(parse_fs), 0);
        check("rst_prst", 32'(parse_rst), 1);
        check("rst_clr", 32'(fifoc_clr), 0);
        check("rst_stb", 32'(cfg_stb), 0);
        check("rst_pkt", 32'(pkt_cnt), 0);
        check("rst_err", 32'(err_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        tick();
        check("rst_hold_prst", 32'(parse_rst), 1);
        rst = 1'b1;
        tick();
        check("rel_prst", 32'(parse_rst), 0);
        check("rel_so", 32'(so), 0);

        // One byte short of a packet: stays idle
        en = 1'b1;
        fifoc_cnt = 8'(PKT_LEN - 1);
        repeat (3) tick();
        check("short_so", 32'(so), 0);
        check("short_busy", 32'(busy), 0);

        // Good packet, done after 20 WAIT cycles
        run_good(20, 0, 1'b1, 1'b0);
        check("good_err", 32'(err_cnt), 0);

        // Bad header: error on the 5th WAIT cycle
        err_model = sat(err_model);
        exp_err_q.push_back(err_model);
        fifoc_cnt = 8'(PKT_LEN);
        tick();
        fifoc_cnt = 8'd0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 5) parse_err = 1'b1;
        end
        tick();
        check("err_fail_so", 32'(so), 5);
        check("err_fail_fs", 32'(parse_fs), 0);
        check("err_fail_prst", 32'(parse_rst), 1);
        parse_err = 1'b0;
        wait_flush("err");

        // Timeout: parser silent
        err_model = sat(err_model);
        exp_err_q.push_back(err_model);
        fifoc_cnt = 8'(PKT_LEN);
        tick();
        fifoc_cnt = 8'd0;
        wcnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (so == 4'd2) wcnt++;
            else break;
        end
        check("tmo_wait_cycles", wcnt, TMO_CYC);
        check("tmo_fail_so", 32'(so), 5);
        wait_flush("tmo");
        check("tmo_pkt", 32'(pkt_cnt), 1);

        // Back-pressure: cfg_rdy low for 10 APPLY cycles
        run_good(3, 10, 1'b1, 1'b0);

        // Done and error in the same cycle: error wins
        err_model = sat(err_model);
        exp_err_q.push_back(err_model);
        fifoc_cnt = 8'(PKT_LEN);
        tick();
        fifoc_cnt = 8'd0;
        tick();
        tick();
        parse_fd  = 1'b1;
        parse_err = 1'b1;
        tick();
        check("both_so", 32'(so), 5);
        parse_fd  = 1'b0;
        parse_err = 1'b0;
        wait_flush("both");
        check("both_pkt", 32'(pkt_cnt), 2);

        // en dropped mid-packet: packet completes, no new start
        run_good(4, 0, 1'b1, 1'b1);
        repeat (3) tick();
        check("endrop_so", 32'(so), 0);
        check("endrop_busy", 32'(busy), 0);
        fifoc_cnt = 8'd0;
        en = 1'b1;

        // Saturation of pkt_cnt
        for (int k = 0; k < 300; k++) run_good(1, 0, 1'b0, 1'b0);
        check("sat_pkt", 32'(pkt_cnt), 255);
        check("sat_err", 32'(err_cnt), 3);

        // Reset pulsed during WAIT abandons the packet
        fifoc_cnt = 8'(PKT_LEN);
        tick();
        fifoc_cnt = 8'd0;
        tick();
        tick();
        check("mid_wait_so", 32'(so), 2);
        parse_fd = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("mid_rst_so", 32'(so), 0);
        check("mid_rst_fs", 32'(parse_fs), 0);
        check("mid_rst_prst", 32'(parse_rst), 1);
        check("mid_rst_pkt", 32'(pkt_cnt), 0);
        check("mid_rst_err", 32'(err_cnt), 0);
        check("mid_rst_busy", 32'(busy), 0);
        tick();
        tick();
        rst = 1'b1;
        parse_fd = 1'b0;
        stb_n = 0;
        repeat (10) begin
            tick();
            stb_n += int'(cfg_stb);
        end
        check("post_rst_stb", stb_n, 0);
        check("post_rst_pkt", 32'(pkt_cnt), 0);
        check("post_rst_so", 32'(so), 0);
        check("pkt_q_empty", exp_pkt_q.size(), 0);
        check("err_q_empty", exp_err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
